// File: rtl/cpu_pkg.sv
// Shared datapath widths and register-address types for the CPU slice.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : cpu_pkg

// File: rtl/regfile_read_port.sv
// One combinational register-file read port with write-to-read bypass.
// R0 (when hardwired) has the highest priority, then the bypass, then the array.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic              wr_commit_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Select array value, overridden by an in-flight committing write, overridden by R0.
  always_comb begin
    rdata_o = regs_i[raddr_i];
    if (wr_commit_i && (raddr_i == waddr_i)) begin
      rdata_o = wdata_i;
    end
    if (ZERO_REG && (raddr_i == ADDR_W'(REG_ZERO))) begin
      rdata_o = '0;
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file_8.sv
// Register file: two bypassed combinational read ports, one synchronous write
// port, a registered debug read port and a saturating committed-write counter.
module register_file_8
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] dbgData,
  output logic [7:0]        writeCount
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] dbgData_q;
  logic [7:0]        writeCount_q;
  logic [7:0]        writeCount_d;
  logic              wr_commit;

  // Gating with rst_n keeps the bypass quiet while reset is held, so reads are 0.
  assign wr_commit = regWrite && rst_n &&
                     !(ZERO_REG && (writeReg == ADDR_W'(REG_ZERO)));

  // Saturating count of writes that actually land in the array.
  always_comb begin
    writeCount_d = writeCount_q;
    if (wr_commit && (writeCount_q != 8'hFF)) begin
      writeCount_d = writeCount_q + 8'd1;
    end
  end

  // Storage, debug snapshot (pre-write value) and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      dbgData_q    <= '0;
      writeCount_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[writeReg] <= writeData;
      end
      dbgData_q    <= regs_q[dbgAddr];
      writeCount_q <= writeCount_d;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .raddr_i    (readReg1),
    .regs_i     (regs_q),
    .wr_commit_i(wr_commit),
    .waddr_i    (writeReg),
    .wdata_i    (writeData),
    .rdata_o    (readData1)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd2 (
    .raddr_i    (readReg2),
    .regs_i     (regs_q),
    .wr_commit_i(wr_commit),
    .waddr_i    (writeReg),
    .wdata_i    (writeData),
    .rdata_o    (readData2)
  );

  assign dbgData    = dbgData_q;
  assign writeCount = writeCount_q;

endmodule : register_file_8

// File: tb/tb_register_file_8.sv
// Scoreboard bench for register_file_8: stimulus queues expected values,
// a monitor pops and compares them when the sample strobe fires.
module tb_register_file_8;

  logic       clk;
  logic       rst_n;
  logic [2:0] readReg1;
  logic [2:0] readReg2;
  logic [2:0] writeReg;
  logic [7:0] writeData;
  logic       regWrite;
  logic [2:0] dbgAddr;
  logic [7:0] readData1;
  logic [7:0] readData2;
  logic [7:0] dbgData;
  logic [7:0] writeCount;

  register_file_8 #(
    .DATA_W  (8),
    .ADDR_W  (3),
    .ZERO_REG(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .regWrite  (regWrite),
    .dbgAddr   (dbgAddr),
    .readData1 (readData1),
    .readData2 (readData2),
    .dbgData   (dbgData),
    .writeCount(writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned sel;   // 0 readData1, 1 readData2, 2 dbgData, 3 writeCount
    logic [7:0]  exp;
  } chk_t;

  chk_t sb_q[$];
  event sample_ev;
  int   errors = 0;
  int   checks = 0;

  // Monitor: on each sample strobe, drain and compare all pending expectations.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        chk_t c;
        logic [7:0] act;
        c = sb_q.pop_front();
        case (c.sel)
          0:       act = readData1;
          1:       act = readData2;
          2:       act = dbgData;
          default: act = writeCount;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_v(input string name, input int unsigned sel, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; readReg1 = '0; readReg2 = '0; writeReg = '0;
    writeData = '0; regWrite = 1'b0; dbgAddr = '0;

    // Power-on reset state.
    expect_v("por_rd1", 0, 8'h00);
    expect_v("por_rd2", 1, 8'h00);
    expect_v("por_dbg", 2, 8'h00);
    expect_v("por_wc",  3, 8'h00);
    sample();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Write R3 then read on both ports.
    regWrite = 1'b1; writeReg = 3'd3; writeData = 8'hA5;
    tick();
    regWrite = 1'b0; readReg1 = 3'd3; readReg2 = 3'd3;
    expect_v("wr_r3_rd1", 0, 8'hA5);
    expect_v("wr_r3_rd2", 1, 8'hA5);
    expect_v("wr_r3_wc",  3, 8'h01);
    sample();

    // Bypass to R5 before the edge, then array holds it.
    readReg1 = 3'd5; writeReg = 3'd5; writeData = 8'h3C;
    expect_v("r5_old", 0, 8'h00);
    sample();
    regWrite = 1'b1;
    expect_v("byp_rd1", 0, 8'h3C);
    expect_v("byp_rd2_other", 1, 8'hA5);
    sample();
    tick();
    regWrite = 1'b0; writeData = 8'hEE;
    expect_v("r5_after", 0, 8'h3C);
    expect_v("r5_wc", 3, 8'h02);
    sample();

    // R0 write is dropped, reads 0 even in the write cycle.
    regWrite = 1'b1; writeReg = 3'd0; writeData = 8'hFF; readReg1 = 3'd0; readReg2 = 3'd0;
    expect_v("r0_byp_rd1", 0, 8'h00);
    expect_v("r0_byp_rd2", 1, 8'h00);
    sample();
    tick();
    regWrite = 1'b0;
    expect_v("r0_after", 0, 8'h00);
    expect_v("r0_wc", 3, 8'h02);
    sample();

    // Debug latency on R2.
    dbgAddr = 3'd2;
    tick();
    regWrite = 1'b1; writeReg = 3'd2; writeData = 8'h11;
    tick();                       // edge N
    regWrite = 1'b0;
    expect_v("dbg_edgeN", 2, 8'h00);
    sample();
    tick();                       // edge N+1
    expect_v("dbg_edgeN1", 2, 8'h11);
    expect_v("dbg_wc", 3, 8'h03);
    sample();
    dbgAddr = 3'd3;
    tick();
    expect_v("dbg_r3", 2, 8'hA5);
    sample();

    // Asynchronous reset mid-cycle with data held and a write pending.
    readReg1 = 3'd3; readReg2 = 3'd5;
    regWrite = 1'b1; writeReg = 3'd3; writeData = 8'h77;
    #2;
    rst_n = 1'b0;
    expect_v("rst_rd1", 0, 8'h00);
    expect_v("rst_rd2", 1, 8'h00);
    expect_v("rst_dbg", 2, 8'h00);
    expect_v("rst_wc",  3, 8'h00);
    sample();
    regWrite = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_v("post_rst_r3", 0, 8'h00);
    sample();

    // Saturation of the write counter.
    regWrite = 1'b1;
    for (int i = 0; i < 254; i++) begin
      writeReg  = 3'(1 + (i % 7));
      writeData = 8'(i);
      tick();
    end
    regWrite = 1'b0;
    expect_v("wc_254", 3, 8'hFE);
    sample();
    regWrite = 1'b1;
    tick();
    regWrite = 1'b0;
    expect_v("wc_255", 3, 8'hFF);
    sample();
    regWrite = 1'b1;
    for (int i = 0; i < 45; i++) begin
      writeReg  = 3'(1 + (i % 7));
      writeData = 8'(i);
      tick();
    end
    regWrite = 1'b0;
    expect_v("wc_300", 3, 8'hFF);
    sample();
    regWrite = 1'b1; writeReg = 3'd7; writeData = 8'h5A;
    tick();
    regWrite = 1'b0; readReg1 = 3'd7;
    expect_v("wc_hold", 3, 8'hFF);
    expect_v("sat_r7", 0, 8'h5A);
    sample();

    #5;
    if (sb_q.size() != 0) begin
      errors += sb_q.size();
      checks += sb_q.size();
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file_8
